// File: rtl/riscy_pkg.sv
// Shared definitions for the memory-side blocks: FSM states, access size
// codes, bus widths and the default fetch-starvation limit.
package riscy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_RESP = 2'b01,
    D_RESP = 2'b10
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  // Halfwords need an even address, words a 4-byte aligned address; code 11
  // is not a legal size and is always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM. Data accesses win
// ties unless fetch has been starved for STARVE_LIMIT data grants. Every
// access is a grant cycle followed by one response cycle.
module mem_arbiter
  import riscy_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  // RAM port
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_en,
  output logic [DATA_W-1:0] ram_d_in,
  output logic [1:0]        ram_d_size,
  output logic              ram_u_en,
  input  logic [DATA_W-1:0] ram_d_out,
  input  logic [DATA_W-1:0] ram_i_out
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             kind_we_q, kind_we_d;
  logic             kind_mis_q, kind_mis_d;
  logic             d_mis;

  assign d_mis = is_misaligned(d_size, d_addr[1:0]);

  // State, starvation counter and the kind of the granted data access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      kind_we_q  <= 1'b0;
      kind_mis_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      kind_we_q  <= kind_we_d;
      kind_mis_q <= kind_mis_d;
    end
  end

  // Arbitration in IDLE: grant, steer the winner's payload onto the RAM
  // port and pick the response state. Grants are held off while in reset.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    kind_we_d  = kind_we_q;
    kind_mis_d = kind_mis_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    ram_addr   = '0;
    ram_w_en   = 1'b0;
    ram_d_in   = '0;
    ram_d_size = SIZE_WORD;
    ram_u_en   = 1'b0;
    if (state_q == IDLE) begin
      if (reset && if_req && (!d_req || starve_q == LIMIT)) begin
        if_gnt   = 1'b1;
        ram_addr = if_addr;
        starve_d = '0;
        state_d  = I_RESP;
      end else if (reset && d_req) begin
        d_gnt      = 1'b1;
        ram_addr   = d_addr;
        ram_w_en   = d_we & ~d_mis;
        ram_d_in   = d_wdata;
        ram_d_size = d_size;
        ram_u_en   = d_unsigned;
        kind_we_d  = d_we;
        kind_mis_d = d_mis;
        state_d    = D_RESP;
        if (if_req && starve_q != LIMIT) begin
          starve_d = starve_q + 1'b1;
        end
      end
    end else begin
      state_d = IDLE;
    end
  end

  // Response cycle: return RAM data for reads, zero for writes and errors.
  always_comb begin
    if_rvalid = (state_q == I_RESP);
    if_rdata  = if_rvalid ? ram_i_out : '0;
    d_rvalid  = (state_q == D_RESP);
    d_err     = d_rvalid & kind_mis_q;
    d_rdata   = (d_rvalid && !kind_we_q && !kind_mis_q) ? ram_d_out : '0;
  end

endmodule
